// File: rtl/nextasic_pkg.sv
// Shared constants and FSM state encoding for the serial packet receiver.
package nextasic_pkg;

    localparam int   OP_BITS     = 16;
    localparam logic START_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP     = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/packet_receiver.sv
// Serial frame receiver: start, 16-bit op, DATA_BITS payload, optional even parity, stop.
// Define PACKET_RECEIVER_PARITY_EN to insert the parity bit between payload and stop.
module packet_receiver
    import nextasic_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_strobe,
    input  logic                 data_in,
    output logic [OP_BITS-1:0]   op_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    rx_state_t             state;
    logic [5:0]            bit_cnt;
    logic [OP_BITS-1:0]    op_sh;
    logic [DATA_BITS-1:0]  data_sh;
    logic                  good_frame;
    logic                  bad_frame;
`ifdef PACKET_RECEIVER_PARITY_EN
    logic                  par_err;
`endif

    assign busy = (state != ST_IDLE);

    // Frame verdict is decided on the stop strobe itself
    always_comb begin
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (bit_strobe && state == ST_STOP) begin
`ifdef PACKET_RECEIVER_PARITY_EN
            good_frame = (data_in == ~START_LEVEL) && !par_err;
`else
            good_frame = (data_in == ~START_LEVEL);
`endif
            bad_frame  = !good_frame;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
`ifdef PACKET_RECEIVER_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (bit_strobe) begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (data_in == START_LEVEL)
                        state <= ST_OP;
                end
                ST_OP: begin
                    if (bit_cnt == 6'(OP_BITS - 1)) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 6'(DATA_BITS - 1)) begin
                        bit_cnt <= '0;
`ifdef PACKET_RECEIVER_PARITY_EN
                        state   <= ST_PARITY;
`else
                        state   <= ST_STOP;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
`ifdef PACKET_RECEIVER_PARITY_EN
                ST_PARITY: begin
                    // Even parity: op, payload and parity bit together hold an even count of ones
                    par_err <= ^{op_sh, data_sh, data_in};
                    state   <= ST_STOP;
                end
`endif
                ST_STOP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift registers are fully rewritten by every frame, so they carry no reset
    always_ff @(posedge clk) begin
        if (bit_strobe) begin
            if (state == ST_OP)
                op_sh <= {op_sh[OP_BITS-2:0], data_in};
            if (state == ST_DATA)
                data_sh <= {data_sh[DATA_BITS-2:0], data_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_out      <= '0;
            data_out    <= '0;
            out_valid   <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= bad_frame;
            if (good_frame) begin
                // A pending frame consumed on this same cycle makes room for the new one
                if (!out_valid || out_ready) begin
                    op_out    <= op_sh;
                    data_out  <= data_sh;
                    out_valid <= 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: table of single frames plus handshake, overrun and reset sequences.
module tb_packet_receiver;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bit_strobe = 1'b0;
    logic          data_in = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   op_out;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          frame_error;
    logic          overrun;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    packet_receiver #(.DATA_BITS(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_strobe  (bit_strobe),
        .data_in     (data_in),
        .op_out      (op_out),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [15:0]   op;
        logic [DW-1:0] data;
        logic          stop;
        logic          exp_valid;
        logic          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two idle cycles, then one strobed bit; returns 1 ns after the sampling edge
    task automatic send_bit(input logic b, input logic rdy);
        tick();
        tick();
        bit_strobe = 1'b1;
        data_in    = b;
        out_ready  = rdy;
        tick();
        bit_strobe = 1'b0;
        data_in    = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] op, input logic [DW-1:0] data,
                              input logic stop, input logic par_flip, input logic rdy);
        send_bit(1'b1, 1'b0);
        for (int i = 15; i >= 0; i--) send_bit(op[i], 1'b0);
        for (int i = DW-1; i >= 0; i--) send_bit(data[i], 1'b0);
`ifdef PACKET_RECEIVER_PARITY_EN
        send_bit((^{op, data}) ^ par_flip, 1'b0);
`else
        if (par_flip) send_bit(1'b0, 1'b0);
`endif
        send_bit(stop, rdy);
    endtask

    task automatic pulse_ready();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic stable;

        vecs[0] = '{"op_c5ef_zero", 16'hC5EF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"op_0000_ones", 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"op_ffff_one",  16'hFFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"op_8001_msb",  16'h8001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"bad_stop",     16'hFFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"op_aaaa_5555", 16'hAAAA, 32'h5555_5555, 1'b0, 1'b1, 1'b0};

        repeat (3) tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_op", 64'(op_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_err", 64'(frame_error), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].op, vecs[v].data, vecs[v].stop, 1'b0, 1'b0);
            chk({vecs[v].name, "_valid"}, 64'(out_valid), 64'(vecs[v].exp_valid));
            chk({vecs[v].name, "_err"}, 64'(frame_error), 64'(vecs[v].exp_err));
            if (vecs[v].exp_valid) begin
                chk({vecs[v].name, "_op"}, 64'(op_out), 64'(vecs[v].op));
                chk({vecs[v].name, "_data"}, 64'(data_out), 64'(vecs[v].data));
            end
            chk({vecs[v].name, "_idle"}, 64'(busy), 64'd0);
            tick();
            chk({vecs[v].name, "_err_pulse"}, 64'(frame_error), 64'd0);
            pulse_ready();
            chk({vecs[v].name, "_cleared"}, 64'(out_valid), 64'd0);
        end

        // Hold without ready for 100 clocks, outputs must not move
        send_frame(16'hC712, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!(out_valid === 1'b1 && op_out === 16'hC712 && data_out === 32'hDEAD_BEEF))
                stable = 1'b0;
            tick();
        end
        chk("hold_stable", 64'(stable), 64'd1);
        chk("hold_op", 64'(op_out), 64'hC712);
        pulse_ready();
        chk("hold_cleared", 64'(out_valid), 64'd0);

        // Old frame consumed on the same cycle the new one completes
        send_frame(16'h1234, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        send_frame(16'h5678, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
        chk("swap_valid", 64'(out_valid), 64'd1);
        chk("swap_op", 64'(op_out), 64'h5678);
        chk("swap_data", 64'(data_out), 64'h2222_2222);
        chk("swap_overrun", 64'(overrun), 64'd0);
        pulse_ready();
        chk("swap_cleared", 64'(out_valid), 64'd0);

        // Back-to-back frames with no consumer
        send_frame(16'h0F00, 32'h0, 1'b0, 1'b0, 1'b0);
        send_frame(16'h1F00, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("ovr_valid", 64'(out_valid), 64'd1);
        chk("ovr_op", 64'(op_out), 64'h0F00);
        chk("ovr_flag", 64'(overrun), 64'd1);
        pulse_ready();
        chk("ovr_cleared", 64'(out_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        reset = 1'b1;
        tick();
        chk("ovr_reset", 64'(overrun), 64'd0);
        reset = 1'b0;
        tick();

        // Bad stop then a good frame
        send_frame(16'hFFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("badstop_err", 64'(frame_error), 64'd1);
        chk("badstop_valid", 64'(out_valid), 64'd0);
        tick();
        chk("badstop_pulse", 64'(frame_error), 64'd0);
        send_frame(16'hC700, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("after_err_valid", 64'(out_valid), 64'd1);
        chk("after_err_op", 64'(op_out), 64'hC700);
        pulse_ready();

        // Reset in the middle of the op field
        send_bit(1'b1, 1'b0);
        for (int i = 15; i >= 6; i--) send_bit(1'((16'hC5EF >> i) & 16'h1), 1'b0);
        chk("mid_busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        send_frame(16'hC5EF, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_op", 64'(op_out), 64'hC5EF);
        chk("post_rst_data", 64'(data_out), 64'd0);
        pulse_ready();

`ifdef PACKET_RECEIVER_PARITY_EN
        send_frame(16'hC701, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        chk("par_bad_err", 64'(frame_error), 64'd1);
        chk("par_bad_valid", 64'(out_valid), 64'd0);
        tick();
        send_frame(16'hC701, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        chk("par_good_err", 64'(frame_error), 64'd0);
        chk("par_good_valid", 64'(out_valid), 64'd1);
        chk("par_good_op", 64'(op_out), 64'hC701);
        chk("par_good_data", 64'(data_out), 64'h1);
        pulse_ready();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, giving the payload bits per frame after the op field.
REQ-002 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port bit_strobe  input  1  one-cycle pulse marking the sampling instant of data_in.
REQ-005 SHALL have port data_in  input  1  serial line from host; idle low; synchronised upstream.
REQ-006 SHALL have port op_out  output  16  received op, MSB first on line, feeds the op decoder.
REQ-007 SHALL have port data_out  output  DATA_BITS  received payload, MSB first on line.
REQ-008 SHALL have port out_valid  output  1  op_out/data_out hold a complete frame.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the frame when high with out_valid.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse on bad stop bit, or bad parity when enabled.
REQ-011 SHALL have port overrun  output  1  sticky flag, frame dropped while out_valid was pending.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL sample data_in only on cycles with bit_strobe high; all other cycles hold state.
REQ-014 SHALL implement states IDLE, OP, DATA, PARITY, STOP.
REQ-015 IDLE: a sampled 1 is the start bit -> OP with bit counter cleared; a sampled 0 stays IDLE.
REQ-016 OP: shift 16 sampled bits MSB first; after the 16th -> DATA.
REQ-017 DATA: shift DATA_BITS bits MSB first; after the last -> PARITY if enabled, else STOP.
REQ-018 PARITY: one sample; even parity over op and data required.
REQ-019 STOP: one sample, 0 required; then -> IDLE on the same strobe.
REQ-020 On valid stop (and parity), SHALL load op_out/data_out and set out_valid the cycle after the stop strobe (latency 1 clk).
REQ-021 On bad stop or parity, SHALL pulse frame_error one cycle, discard the frame, leave out_valid unchanged, return IDLE.
REQ-022 out_valid SHALL stay high, with op_out/data_out stable, until a cycle with out_ready high, then clear next cycle.
REQ-023 If a good frame completes while out_valid is high and out_ready low that cycle, SHALL drop the new frame and set overrun until reset.
REQ-024 If out_ready is high in the same cycle a new frame completes, SHALL accept the old frame and load the new one, leaving out_valid high.
REQ-025 Shift register SHALL be separate from the output registers so reception continues while out_valid is pending.
REQ-026 Bit counter SHALL be 6 bits wide, sized to max(16, DATA_BITS); DATA_BITS above 63 is illegal.

Reset
REQ-027 Asserting reset, at any time including mid-frame, SHALL immediately force IDLE and zero op_out, data_out, out_valid, frame_error, overrun, busy and the counters.
REQ-028 After reset deassertion, SHALL wait for a fresh start bit; no partial frame survives.

Configuration
REQ-029 With macro PACKET_RECEIVER_PARITY_EN defined, SHALL include the PARITY state, and a parity mismatch SHALL pulse frame_error.
REQ-030 Without PACKET_RECEIVER_PARITY_EN, SHALL omit PARITY and go DATA -> STOP; frame length becomes 1+16+DATA_BITS+1.

Structure
REQ-031 State encoding enum and constants OP_BITS=16 and START_LEVEL=1 SHALL be in the shared package nextasic_pkg.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Frame op 0xC5EF, data 0x00000000, good stop -> out_valid after 1 clk, op_out=0xC5EF, data_out=0.
REQ-034 Frame op 0xC712, data 0xDEADBEEF, out_ready held low 100 clks -> outputs stable, out_valid high throughout; out_ready pulse clears it.
REQ-035 Two back-to-back frames 0x0F00 then 0x1F00, out_ready low -> first retained, overrun=1, second dropped.
REQ-036 Frame 0xFFFF with stop bit 1 -> frame_error pulses one cycle, out_valid stays 0, next frame 0xC700 received correctly.
REQ-037 Reset asserted after 10 op bits, then full frame 0xC5EF -> no output from the partial frame; 0xC5EF delivered.
REQ-038 With PACKET_RECEIVER_PARITY_EN, frame 0xC701/0x00000001 with wrong parity bit -> frame_error=1, no out_valid; correct parity -> delivered.
